// File: rtl/ft64_bitfield_arb.sv
// Two-slot round-robin arbiter with a registered issue stage and result stage
// wrapped around the combinational bitfield unit. Optional flush port: FT64_BFARB_FLUSH_EN.

module ft64_bitfield #(
    parameter int DWIDTH = 64
) (
    input  logic [3:0]        op,
    input  logic [5:0]        mb,
    input  logic [5:0]        me,
    input  logic [4:0]        imm,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] o,
    output logic [DWIDTH-1:0] mask
);
    localparam logic [3:0] OP_SET   = 4'd0;
    localparam logic [3:0] OP_CHG   = 4'd2;
    localparam logic [3:0] OP_INS   = 4'd3;
    localparam logic [3:0] OP_INSI  = 4'd4;
    localparam logic [3:0] OP_EXT   = 4'd5;
    localparam logic [3:0] OP_EXTU  = 4'd6;

    logic [5:0]        wd;
    logic [DWIDTH-1:0] ext;
    logic [DWIDTH-1:0] fld_u;
    logic [DWIDTH-1:0] fld_s;
    logic [DWIDTH-1:0] ins_b;
    logic [DWIDTH-1:0] ins_i;

    assign wd    = me - mb;
    assign ext   = a >> mb;
    assign ins_b = (b << mb) & mask;
    assign ins_i = ({{(DWIDTH-5){1'b0}}, imm} << mb) & mask;

    // Field runs mb..me inclusive and wraps through bit 0 when me < mb.
    always_comb begin
        mask  = '0;
        fld_u = '0;
        fld_s = '0;
        for (int i = 0; i < DWIDTH; i++) begin
            mask[i]  = ((i >= int'(mb)) ^ (i <= int'(me))) ^ (me >= mb);
            fld_u[i] = (i <= int'(wd)) ? ext[i] : 1'b0;
            fld_s[i] = (i <= int'(wd)) ? ext[i] : ext[wd];
        end
    end

    // BFCLR (op 1) and all undefined ops fall to the default of zero.
    always_comb begin
        o = '0;
        case (op)
            OP_SET:  o = a | mask;
            OP_CHG:  o = a ^ mask;
            OP_INS:  o = (a & ~mask) | ins_b;
            OP_INSI: o = (a & ~mask) | ins_i;
            OP_EXT:  o = fld_s;
            OP_EXTU: o = fld_u;
            default: o = '0;
        endcase
    end
endmodule

module ft64_bitfield_arb #(
    parameter int DWIDTH = 64,
    parameter int TAGW   = 5
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FT64_BFARB_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              req0_v,
    output logic              req0_rdy,
    input  logic [31:0]       req0_inst,
    input  logic [DWIDTH-1:0] req0_a,
    input  logic [DWIDTH-1:0] req0_b,
    input  logic [TAGW-1:0]   req0_tag,
    input  logic              req1_v,
    output logic              req1_rdy,
    input  logic [31:0]       req1_inst,
    input  logic [DWIDTH-1:0] req1_a,
    input  logic [DWIDTH-1:0] req1_b,
    input  logic [TAGW-1:0]   req1_tag,
    output logic              res_v,
    input  logic              res_rdy,
    output logic [DWIDTH-1:0] res_o,
    output logic [DWIDTH-1:0] res_mask,
    output logic [TAGW-1:0]   res_tag,
    output logic              res_src,
    output logic              res_ill,
    output logic              busy
);
    logic              flush_i;
    logic              s1_v;
    logic              s2_v;
    logic              rr;
    logic              s1_adv;
    logic              s2_adv;
    logic              gnt0;
    logic              gnt1;
    logic [3:0]        s1_op;
    logic [5:0]        s1_me;
    logic [5:0]        s1_mb;
    logic [4:0]        s1_imm;
    logic [DWIDTH-1:0] s1_a;
    logic [DWIDTH-1:0] s1_b;
    logic [TAGW-1:0]   s1_tag;
    logic              s1_src;
    logic [DWIDTH-1:0] unit_o;
    logic [DWIDTH-1:0] unit_mask;
    logic              s1_ill;
    logic              unused_inst_bits;

`ifdef FT64_BFARB_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign unused_inst_bits = ^{req0_inst[15:11], req0_inst[5:0],
                                req1_inst[15:11], req1_inst[5:0]};

    assign s2_adv = !s2_v || res_rdy;
    assign s1_adv = !s1_v || s2_adv;

    // Grants are suppressed during reset and flush so no transfer can be lost.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !flush_i && s1_adv) begin
            gnt0 = req0_v && (!req1_v || !rr);
            gnt1 = req1_v && (!req0_v ||  rr);
        end
    end

    assign req0_rdy = gnt0;
    assign req1_rdy = gnt1;
    assign s1_ill   = (s1_op > 4'd6);

    ft64_bitfield #(.DWIDTH(DWIDTH)) u_bitfield (
        .op   (s1_op),
        .mb   (s1_mb),
        .me   (s1_me),
        .imm  (s1_imm),
        .a    (s1_a),
        .b    (s1_b),
        .o    (unit_o),
        .mask (unit_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            rr       <= 1'b0;
            s1_op    <= '0;
            s1_me    <= '0;
            s1_mb    <= '0;
            s1_imm   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
            s1_src   <= 1'b0;
            res_o    <= '0;
            res_mask <= '0;
            res_tag  <= '0;
            res_src  <= 1'b0;
            res_ill  <= 1'b0;
        end else if (flush_i) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v <= gnt0 || gnt1;
                if (gnt1) begin
                    s1_op  <= req1_inst[31:28];
                    s1_me  <= req1_inst[27:22];
                    s1_mb  <= req1_inst[21:16];
                    s1_imm <= req1_inst[10:6];
                    s1_a   <= req1_a;
                    s1_b   <= req1_b;
                    s1_tag <= req1_tag;
                    s1_src <= 1'b1;
                end else if (gnt0) begin
                    s1_op  <= req0_inst[31:28];
                    s1_me  <= req0_inst[27:22];
                    s1_mb  <= req0_inst[21:16];
                    s1_imm <= req0_inst[10:6];
                    s1_a   <= req0_a;
                    s1_b   <= req0_b;
                    s1_tag <= req0_tag;
                    s1_src <= 1'b0;
                end
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    res_o    <= s1_ill ? '0 : unit_o;
                    res_mask <= unit_mask;
                    res_tag  <= s1_tag;
                    res_src  <= s1_src;
                    res_ill  <= s1_ill;
                end
            end
            if (gnt0 || gnt1) rr <= gnt0;
        end
    end

    assign res_v = s2_v;
    assign busy  = s1_v || s2_v;
endmodule

// File: tb/tb_ft64_bitfield_arb.sv
// Self-checking bench for ft64_bitfield_arb: directed scenarios plus a randomized
// run against a queue-based reference model of the two-deep elastic pipeline.
module tb_ft64_bitfield_arb;
    localparam int DW = 64;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_v, req1_v, req0_rdy, req1_rdy;
    logic [31:0]   req0_inst, req1_inst;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [TW-1:0] req0_tag, req1_tag;
    logic          res_v, res_rdy, res_src, res_ill, busy;
    logic [DW-1:0] res_o, res_mask;
    logic [TW-1:0] res_tag;
`ifdef FT64_BFARB_FLUSH_EN
    logic          flush = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] o;
        logic [63:0] mask;
        logic [4:0]  tag;
        logic        src;
        logic        ill;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc;
    logic rr_m;

    always #5 clk = ~clk;

    ft64_bitfield_arb #(.DWIDTH(DW), .TAGW(TW)) dut (
        .clk(clk), .rst(rst),
`ifdef FT64_BFARB_FLUSH_EN
        .flush(flush),
`endif
        .req0_v(req0_v), .req0_rdy(req0_rdy), .req0_inst(req0_inst),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_v(req1_v), .req1_rdy(req1_rdy), .req1_inst(req1_inst),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .res_v(res_v), .res_rdy(res_rdy), .res_o(res_o), .res_mask(res_mask),
        .res_tag(res_tag), .res_src(res_src), .res_ill(res_ill), .busy(busy)
    );

    function automatic logic [63:0] ref_mask(input logic [5:0] mb, input logic [5:0] me);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (me >= mb) m[i] = (i >= int'(mb)) && (i <= int'(me));
            else          m[i] = (i >= int'(mb)) || (i <= int'(me));
        end
        return m;
    endfunction

    function automatic logic [63:0] ref_res(input logic [31:0] inst, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [3:0]  op;
        logic [5:0]  me, mb;
        logic [63:0] m, fmask, fld, immx;
        int          w;
        op    = inst[31:28];
        me    = inst[27:22];
        mb    = inst[21:16];
        immx  = 64'(inst[10:6]);
        m     = ref_mask(mb, me);
        w     = ((int'(me) - int'(mb)) & 63) + 1;
        fmask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        fld   = (a >> mb) & fmask;
        case (op)
            4'd0: return a | m;
            4'd2: return a ^ m;
            4'd3: return (a & ~m) | ((b << mb) & m);
            4'd4: return (a & ~m) | ((immx << mb) & m);
            4'd5: return fld[w-1] ? (fld | ~fmask) : fld;
            4'd6: return fld;
            default: return 64'd0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; req0_v = 0; req1_v = 0; res_rdy = 0;
        req0_inst = 0; req1_inst = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        req0_tag = 0; req1_tag = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); cyc = 0; rr_m = 1'b0;
    endtask

    // Presents one request on a slot for a single cycle and waits until it reaches S2.
    task automatic send_one(input bit slot, input logic [31:0] inst, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] tag);
        if (slot) begin req1_v = 1; req1_inst = inst; req1_a = a; req1_b = b; req1_tag = tag; end
        else      begin req0_v = 1; req0_inst = inst; req0_a = a; req0_b = b; req0_tag = tag; end
        @(posedge clk); #1;
        req0_v = 0; req1_v = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_v = 1; req1_v = 1; res_rdy = 1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req0_rdy, req1_rdy} !== 2'b00) begin
            failures++; $display("FAIL reset_rdy got=%b exp=00", {req0_rdy, req1_rdy});
        end
        checks++;
        if ({res_v, busy, res_src, res_ill} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {res_v, busy, res_src, res_ill});
        end
        checks++;
        if ({res_o, res_mask, res_tag} !== '0) begin
            failures++; $display("FAIL reset_data got o=%h m=%h t=%h exp=0", res_o, res_mask, res_tag);
        end
        do_reset();
    endtask

    task automatic test_single_op();
        do_reset();
        res_rdy = 1; req0_v = 1; req0_inst = 32'h63C80000; req0_a = 64'h12345678;
        req0_b = 0; req0_tag = 5'd3;
        @(negedge clk);
        checks++;
        if ({req0_rdy, req1_rdy} !== 2'b10) begin
            failures++; $display("FAIL single_rdy got=%b exp=10", {req0_rdy, req1_rdy});
        end
        @(posedge clk); #1; req0_v = 0;
        @(negedge clk);
        checks++;
        if (res_v !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", res_v); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({res_v, res_o, res_mask, res_tag, res_src, res_ill} !==
            {1'b1, 64'h56, 64'hFF00, 5'd3, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_res got v=%b o=%h m=%h t=%0d s=%b i=%b exp v=1 o=56 m=ff00 t=3 s=0 i=0",
                     res_v, res_o, res_mask, res_tag, res_src, res_ill);
        end
    endtask

    task automatic test_bfset();
        do_reset();
        res_rdy = 1;
        send_one(1'b1, 32'h00C00000, 64'h0, 64'h0, 5'd9);
        @(negedge clk);
        checks++;
        if ({res_v, res_o, res_mask, res_src, res_ill} !== {1'b1, 64'hF, 64'hF, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL bfset got v=%b o=%h m=%h s=%b i=%b exp v=1 o=f m=f s=1 i=0",
                     res_v, res_o, res_mask, res_src, res_ill);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        res_rdy = 1;
        send_one(1'b0, 32'h70000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd7);
        @(negedge clk);
        checks++;
        if ({res_v, res_ill, res_o, res_mask} !== {1'b1, 1'b1, 64'h0, 64'h1}) begin
            failures++;
            $display("FAIL illegal got v=%b i=%b o=%h m=%h exp v=1 i=1 o=0 m=1",
                     res_v, res_ill, res_o, res_mask);
        end
    endtask

    task automatic test_contention();
        do_reset();
        res_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            req0_v = (i < 6); req1_v = (i < 6);
            req0_tag = 5'(i); req1_tag = 5'(i);
            req0_inst = 32'h00C00000; req1_inst = 32'h00C00000;
            @(negedge clk);
            checks++;
            if ({req0_rdy, req1_rdy} !== ((i < 6) ? ((i % 2 == 0) ? 2'b10 : 2'b01) : 2'b00)) begin
                failures++; $display("FAIL contention_grant i=%0d got=%b", i, {req0_rdy, req1_rdy});
            end
            if (i >= 2) begin
                checks++;
                if ({res_v, res_tag, res_src} !== {1'b1, 5'(i - 2), 1'((i - 2) % 2)}) begin
                    failures++;
                    $display("FAIL contention_res i=%0d got v=%b t=%0d s=%b exp v=1 t=%0d s=%0d",
                             i, res_v, res_tag, res_src, i - 2, (i - 2) % 2);
                end
            end
            @(posedge clk); #1;
        end
        req0_v = 0; req1_v = 0;
    endtask

    task automatic test_backpressure();
        logic [4:0] got[$];
        do_reset();
        res_rdy = 0; req0_v = 1; req0_inst = 32'h63C80000; req0_tag = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (req0_rdy !== (k < 2)) begin
                failures++; $display("FAIL bp_rdy k=%0d got=%b exp=%0d", k, req0_rdy, k < 2);
            end
            if (k >= 2) begin
                checks++;
                if ({res_v, res_tag} !== {1'b1, 5'd0}) begin
                    failures++; $display("FAIL bp_hold k=%0d got v=%b t=%0d exp v=1 t=0", k, res_v, res_tag);
                end
            end
            @(posedge clk); #1;
            if (k < 2) req0_tag = req0_tag + 1;
        end
        req0_v = 0; res_rdy = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (res_v) got.push_back(res_tag);
            @(posedge clk); #1;
        end
        checks++;
        if (got.size() != 2 || got[0] !== 5'd0 || got[1] !== 5'd1) begin
            failures++; $display("FAIL bp_drain got count=%0d exp count=2 tags 0,1", got.size());
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        res_rdy = 0;
        send_one(1'b0, 32'h00C00000, 64'h0, 64'h0, 5'd1);
        send_one(1'b1, 32'h00C00000, 64'h0, 64'h0, 5'd2);
        rst = 1;
        @(posedge clk); #1; rst = 0; res_rdy = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({res_v, busy} !== 2'b00) begin
                failures++; $display("FAIL mid_reset k=%0d got v=%b busy=%b exp 00", k, res_v, busy);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef FT64_BFARB_FLUSH_EN
    task automatic test_flush();
        do_reset();
        res_rdy = 0; req0_v = 1; req0_inst = 32'h00C00000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req1_v = 1; flush = 1;
        @(negedge clk);
        checks++;
        if ({req0_rdy, req1_rdy} !== 2'b00) begin
            failures++; $display("FAIL flush_nogrant got=%b exp=00", {req0_rdy, req1_rdy});
        end
        @(posedge clk); #1; flush = 0;
        @(negedge clk);
        checks++;
        if ({res_v, busy} !== 2'b00) begin
            failures++; $display("FAIL flush_clear got v=%b busy=%b exp 00", res_v, busy);
        end
        checks++;
        if ({req0_rdy, req1_rdy} !== 2'b01) begin
            failures++; $display("FAIL flush_rr got=%b exp=01", {req0_rdy, req1_rdy});
        end
        @(posedge clk); #1;
        req0_v = 0; req1_v = 0;
    endtask
`endif

    task automatic test_random();
        logic e0, e1, erv, s1a;
        exp_t e;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req0_v = ($urandom_range(0, 3) != 0);
            req1_v = ($urandom_range(0, 3) != 0);
            res_rdy = ($urandom_range(0, 3) != 0);
            req0_inst = {4'($urandom_range(0, 8)), 6'($urandom), 6'($urandom), 16'($urandom)};
            req1_inst = {4'($urandom_range(0, 8)), 6'($urandom), 6'($urandom), 16'($urandom)};
            req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
            req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
            req0_tag = 5'($urandom); req1_tag = 5'($urandom);
            s1a = (q.size() < 2) || res_rdy;
            e0  = s1a && req0_v && (!req1_v || !rr_m);
            e1  = s1a && req1_v && (!req0_v || rr_m);
            erv = (q.size() > 0) && (q[0].acc + 2 <= cyc);
            @(negedge clk);
            checks++;
            if ({req0_rdy, req1_rdy} !== {e0, e1}) begin
                failures++; $display("FAIL rand_grant n=%0d got=%b exp=%b", n, {req0_rdy, req1_rdy}, {e0, e1});
            end
            checks++;
            if ({res_v, busy} !== {erv, q.size() > 0}) begin
                failures++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, {res_v, busy}, {erv, q.size() > 0});
            end
            if (erv) begin
                checks++;
                if ({res_o, res_mask, res_tag, res_src, res_ill} !==
                    {q[0].o, q[0].mask, q[0].tag, q[0].src, q[0].ill}) begin
                    failures++;
                    $display("FAIL rand_data n=%0d got o=%h m=%h t=%0d s=%b i=%b exp o=%h m=%h t=%0d s=%b i=%b",
                             n, res_o, res_mask, res_tag, res_src, res_ill,
                             q[0].o, q[0].mask, q[0].tag, q[0].src, q[0].ill);
                end
            end
            if (erv && res_rdy) void'(q.pop_front());
            if (e0 || e1) begin
                e.src  = e1;
                e.tag  = e1 ? req1_tag : req0_tag;
                e.ill  = e1 ? (req1_inst[31:28] > 4'd6) : (req0_inst[31:28] > 4'd6);
                e.o    = e1 ? ref_res(req1_inst, req1_a, req1_b) : ref_res(req0_inst, req0_a, req0_b);
                e.mask = e1 ? ref_mask(req1_inst[21:16], req1_inst[27:22])
                            : ref_mask(req0_inst[21:16], req0_inst[27:22]);
                e.acc  = cyc;
                q.push_back(e);
                rr_m = e0;
            end
            cyc++;
            @(posedge clk); #1;
        end
        req0_v = 0; req1_v = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_op();
        test_bfset();
        test_illegal();
        test_contention();
        test_backpressure();
        test_mid_reset();
`ifdef FT64_BFARB_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
